uart_rx: RTL and testbench

- 8N1 UART receiver: the receive counterpart to the team's 8-bit UART transmitter.
- Takes the asynchronous serial line `rxd`, synchronises it, and detects the start bit.
- Samples each bit at its midpoint using a clock-divided bit timer.
- Presents each received byte on `data` with a one-cycle `valid` strobe; flags bad stop bits on `framing_err`.
- Sits between the board's serial input pin and user logic. Its outputs also drive debug LEDs/pins.

---
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 2-flop input synchroniser and mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               w_rxd_s;

  assign w_rxd_s = r_sync[1];
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync      <= 2'b11;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      data        <= 8'h00;
      valid       <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rxd};
      valid       <= 1'b0;
      framing_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxd_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt <= '0;
            r_idx <= '0;
            // A line that is high again at mid start bit was only a glitch
            r_state <= w_rxd_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd_s, r_shift[7:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt <= '0;
            if (w_rxd_s) begin
              data    <= r_shift;
              valid   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              framing_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rxd_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed plus randomized self-checking bench for uart_rx at 16 clocks/bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int c_CPB = 16;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_fe = 0;
  int         n_both = 0;
  int         last_valid_cyc = 0;
  logic       busy_at_valid = 1'b1;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ(160000),
    .BAUD    (10000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .framing_err(framing_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder only; all judgements are made in the stimulus block
  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      n_valid++;
      last_valid_cyc = cyc;
      busy_at_valid  = busy;
    end
    if (framing_err) n_fe++;
    if (valid && framing_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference framing: start 0, data LSB first, then the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic bits [10];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = ((b >> i) & 8'h01) != 0;
    bits[9] = stop_bit;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      idle(c_CPB);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    check({tag, "_avail"}, (got_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (got_q.size() > 0) check(tag, {24'd0, got_q.pop_front()}, {24'd0, b});
  endtask

  initial begin
    int t0;
    int lat;
    int nv0;
    int nf0;
    int busy_cnt;
    logic [7:0] b;

    reset = 1'b0;
    rxd   = 1'b1;
    idle(3);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, framing_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    reset = 1'b1;
    idle(100);
    check("idle_valid_cnt", n_valid, 0);
    check("idle_fe_cnt", n_fe, 0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single frame with latency measured from the start-bit falling edge
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(4);
    check("a5_count", n_valid, 1);
    expect_byte("a5_data", 8'hA5);
    lat = last_valid_cyc - t0;
    check("a5_latency_window", (lat >= 9 * c_CPB + c_CPB / 2 && lat <= 9 * c_CPB + c_CPB / 2 + 6) ? 32'd1 : 32'd0, 32'd1);
    check("a5_busy_at_valid", {31'd0, busy_at_valid}, 32'd0);

    // Back-to-back frames
    nv0 = n_valid;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    check("b2b_count", n_valid - nv0, 2);
    expect_byte("b2b_first", 8'h00);
    expect_byte("b2b_second", 8'hFF);
    check("b2b_fe", n_fe, 0);

    // Bad stop bit followed by a held-low break
    nv0 = n_valid;
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("brk_fe_count", n_fe, 1);
    check("brk_no_valid", n_valid - nv0, 0);
    check("brk_data_kept", {24'd0, data}, 32'hFF);
    check("brk_busy_low_line", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    idle(6);
    check("brk_busy_released", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(4);
    expect_byte("after_brk", 8'h81);

    // Short glitch must not start a frame
    nv0 = n_valid;
    nf0 = n_fe;
    busy_cnt = 0;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_cnt++;
      idle(1);
    end
    check("glitch_busy_bounded", (busy_cnt >= 1 && busy_cnt <= 8) ? 32'd1 : 32'd0, 32'd1);
    check("glitch_no_valid", n_valid - nv0, 0);
    check("glitch_no_fe", n_fe - nf0, 0);

    // Randomized frames with random idle gaps, checked against the sent bytes
    nf0 = n_fe;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 20));
    end
    idle(4);
    check("rand_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) expect_byte("rand_byte", exp_q.pop_front());
    check("rand_no_fe", n_fe - nf0, 0);

    // Reset in the middle of data bit 4
    nv0 = n_valid;
    rxd = 1'b0;
    idle(c_CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      idle(c_CPB);
    end
    rxd = 1'b1;
    idle(c_CPB / 2);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ferr", {31'd0, framing_err}, 32'd0);
    idle(3);
    reset = 1'b1;
    idle(30);
    check("midrst_no_pulse", n_valid - nv0, 0);
    send_frame(8'h5A, 1'b1);
    idle(4);
    expect_byte("post_rst", 8'h5A);
    check("post_rst_data_port", {24'd0, data}, 32'h5A);

    check("never_both", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
